// File: rtl/svreal_accum_pkg.sv
// svreal_accum_pkg: shared types and helpers for the svreal accumulate blocks.
`default_nettype none

package svreal_accum_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   function automatic int align_shift(input int exp_in, input int exp_acc);
      return exp_in - exp_acc;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Saturation bounds of a signed field of the given width (width <= 63).
   function automatic longint sat_max(input int width);
      return (longint'(1) <<< (width - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

endpackage

`default_nettype wire

// File: rtl/svreal_align_sat.sv
// svreal_align_sat: aligns a fixed-point input to the accumulator format,
// adds it to the accumulator value and saturates the result.
`default_nettype none

module svreal_align_sat
   import svreal_accum_pkg::*;
#(
   parameter int WIDTH_IN  = 18,
   parameter int EXP_IN    = -10,
   parameter int WIDTH_ACC = 24,
   parameter int EXP_ACC   = -10
) (
   input  logic signed [WIDTH_ACC-1:0] i_acc,
   input  logic signed [WIDTH_IN-1:0]  i_in_value,
   output logic signed [WIDTH_ACC-1:0] o_sum,
   output logic                        o_sat
);

   localparam int c_SH    = align_shift(EXP_IN, EXP_ACC);
   localparam int c_LSH   = (c_SH > 0) ? c_SH : 0;
   localparam int c_RSH   = (c_SH < 0) ? -c_SH : 0;
   // Wide enough for either operand after a left shift plus a carry and sign.
   localparam int c_SUM_W = max_int(WIDTH_ACC, WIDTH_IN) + c_LSH + 2;

   localparam logic signed [c_SUM_W-1:0] c_MAX = c_SUM_W'(sat_max(WIDTH_ACC));
   localparam logic signed [c_SUM_W-1:0] c_MIN = c_SUM_W'(sat_min(WIDTH_ACC));

   logic signed [c_SUM_W-1:0] w_in_ext;
   logic signed [c_SUM_W-1:0] w_aligned;
   logic signed [c_SUM_W-1:0] w_acc_ext;
   logic signed [c_SUM_W-1:0] w_sum;

   assign w_in_ext  = c_SUM_W'(i_in_value);
   // Arithmetic right shift floors negative values toward minus infinity.
   assign w_aligned = (w_in_ext <<< c_LSH) >>> c_RSH;
   assign w_acc_ext = c_SUM_W'(i_acc);
   assign w_sum     = w_acc_ext + w_aligned;

   always_comb begin
      o_sat = 1'b0;
      o_sum = w_sum[WIDTH_ACC-1:0];
      if (w_sum > c_MAX) begin
         o_sum = c_MAX[WIDTH_ACC-1:0];
         o_sat = 1'b1;
      end else if (w_sum < c_MIN) begin
         o_sum = c_MIN[WIDTH_ACC-1:0];
         o_sat = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/svreal_accum.sv
// svreal_accum: saturating fixed-point accumulator summing N_ACC products per
// frame and presenting each sum on a valid/ready output.
`default_nettype none

module svreal_accum
   import svreal_accum_pkg::*;
#(
   parameter int  WIDTH_IN  = 18,
   parameter int  EXP_IN    = -10,
   parameter int  WIDTH_ACC = 24,
   parameter int  EXP_ACC   = -10,
   parameter int  N_ACC     = 4,
   localparam int CNT_W     = $clog2(N_ACC + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_clear,
   input  logic signed [WIDTH_IN-1:0]  i_in_value,
   input  logic                        i_in_valid,
   output logic                        o_in_ready,
   output logic signed [WIDTH_ACC-1:0] o_out_value,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output logic                        o_out_sat,
   output logic [CNT_W-1:0]            o_count
);

   state_t                      r_state,     w_state_nxt;
   logic signed [WIDTH_ACC-1:0] r_acc,       w_acc_nxt;
   logic [CNT_W-1:0]            r_count,     w_count_nxt;
   logic                        r_sat,       w_sat_nxt;
   logic signed [WIDTH_ACC-1:0] r_out_value, w_out_value_nxt;
   logic                        r_out_sat,   w_out_sat_nxt;

   logic signed [WIDTH_ACC-1:0] w_sum;
   logic                        w_add_sat;
   logic                        w_accept;

   svreal_align_sat #(
      .WIDTH_IN  (WIDTH_IN),
      .EXP_IN    (EXP_IN),
      .WIDTH_ACC (WIDTH_ACC),
      .EXP_ACC   (EXP_ACC)
   ) u_align_sat (
      .i_acc      (r_acc),
      .i_in_value (i_in_value),
      .o_sum      (w_sum),
      .o_sat      (w_add_sat)
   );

   assign o_in_ready  = (r_state == ACCUM) && !i_clear;
   assign o_out_valid = (r_state == HOLD);
   assign o_out_value = r_out_value;
   assign o_out_sat   = r_out_sat;
   assign o_count     = r_count;
   assign w_accept    = i_in_valid && o_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ACCUM;
         r_acc       <= '0;
         r_count     <= '0;
         r_sat       <= 1'b0;
         r_out_value <= '0;
         r_out_sat   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_count     <= w_count_nxt;
         r_sat       <= w_sat_nxt;
         r_out_value <= w_out_value_nxt;
         r_out_sat   <= w_out_sat_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_count_nxt     = r_count;
      w_sat_nxt       = r_sat;
      w_out_value_nxt = r_out_value;
      w_out_sat_nxt   = r_out_sat;
      // clear outranks both accumulation and output transfer.
      if (i_clear) begin
         w_state_nxt = ACCUM;
         w_acc_nxt   = '0;
         w_count_nxt = '0;
         w_sat_nxt   = 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  w_acc_nxt   = w_sum;
                  w_sat_nxt   = r_sat | w_add_sat;
                  w_count_nxt = r_count + CNT_W'(1);
                  if (r_count == CNT_W'(N_ACC - 1)) begin
                     w_out_value_nxt = w_sum;
                     w_out_sat_nxt   = r_sat | w_add_sat;
                     w_state_nxt     = HOLD;
                  end
               end
            end
            HOLD: begin
               if (i_out_ready) begin
                  w_state_nxt = ACCUM;
                  w_acc_nxt   = '0;
                  w_count_nxt = '0;
                  w_sat_nxt   = 1'b0;
               end
            end
            default: w_state_nxt = ACCUM;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_svreal_accum.sv
// tb_svreal_accum: randomized scoreboard bench for three svreal_accum builds.
`default_nettype none
`timescale 1ns/1ps

module tb_svreal_accum;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Group 0 drives instances A (defaults) and B (narrow acc, EXP_ACC=-8).
   logic               clr0 = 1'b0, iv0 = 1'b0, rdy0 = 1'b1;
   logic signed [17:0] val0 = '0;
   // Group 1 drives instance C (N_ACC=1).
   logic               clr1 = 1'b0, iv1 = 1'b0, rdy1 = 1'b1;
   logic signed [17:0] val1 = '0;

   logic signed [23:0] ova, ovc;
   logic signed [13:0] ovb;
   logic [2:0]         cnta, cntb;
   logic [0:0]         cntc;
   logic               ira, irb, irc, vla, vlb, vlc, sta, stb, stc;

   svreal_accum u_a (
      .clk(clk), .rst_n(rst_n), .i_clear(clr0), .i_in_value(val0), .i_in_valid(iv0),
      .o_in_ready(ira), .o_out_value(ova), .o_out_valid(vla), .i_out_ready(rdy0),
      .o_out_sat(sta), .o_count(cnta));

   svreal_accum #(.WIDTH_ACC(14), .EXP_ACC(-8)) u_b (
      .clk(clk), .rst_n(rst_n), .i_clear(clr0), .i_in_value(val0), .i_in_valid(iv0),
      .o_in_ready(irb), .o_out_value(ovb), .o_out_valid(vlb), .i_out_ready(rdy0),
      .o_out_sat(stb), .o_count(cntb));

   svreal_accum #(.N_ACC(1)) u_c (
      .clk(clk), .rst_n(rst_n), .i_clear(clr1), .i_in_value(val1), .i_in_valid(iv1),
      .o_in_ready(irc), .o_out_value(ovc), .o_out_valid(vlc), .i_out_ready(rdy1),
      .o_out_sat(stc), .o_count(cntc));

   longint outv [3];
   logic   in_rdy [3], out_vld [3], out_st [3];
   int     cnt [3];
   assign outv[0] = longint'(ova);  assign outv[1] = longint'(ovb);  assign outv[2] = longint'(ovc);
   assign in_rdy[0] = ira;  assign in_rdy[1] = irb;  assign in_rdy[2] = irc;
   assign out_vld[0] = vla; assign out_vld[1] = vlb; assign out_vld[2] = vlc;
   assign out_st[0] = sta;  assign out_st[1] = stb;  assign out_st[2] = stc;
   assign cnt[0] = int'(cnta); assign cnt[1] = int'(cntb); assign cnt[2] = int'(cntc);

   int n_vec = 0;
   int n_err = 0;

   // Reference model: frame-level view of each instance.
   bit     hold [3];
   int     mcnt [3];
   longint macc [3];
   bit     msat [3];
   longint fv [3][8];
   bit     fs [3][8];
   int     wp [3];
   int     rp [3];

   function automatic int acc_w(int k);  return (k == 1) ? 14 : 24; endfunction
   function automatic int shift(int k);  return (k == 1) ? -2 : 0;  endfunction
   function automatic int n_acc(int k);  return (k == 2) ? 1 : 4;   endfunction

   // value * 2^sh, rounding toward minus infinity when sh < 0.
   function automatic longint align(longint v, int sh);
      longint d, q;
      if (sh >= 0) return v * (longint'(1) << sh);
      d = longint'(1) << (-sh);
      q = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;
      return q;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         hold[k] = 0; mcnt[k] = 0; macc[k] = 0; msat[k] = 0; rp[k] = wp[k];
      end
   endtask

   task automatic step(input int k, input bit v, input longint x, input bit r, input bit c);
      longint s, hi, lo;
      hi = (longint'(1) << (acc_w(k) - 1)) - 1;
      lo = -(longint'(1) << (acc_w(k) - 1));
      if (c) begin
         if (hold[k]) wp[k]--;
         hold[k] = 0; mcnt[k] = 0; macc[k] = 0; msat[k] = 0;
      end else if (hold[k]) begin
         if (r) begin hold[k] = 0; mcnt[k] = 0; macc[k] = 0; msat[k] = 0; end
      end else if (v) begin
         s = macc[k] + align(x, shift(k));
         if (s > hi) begin s = hi; msat[k] = 1; end
         if (s < lo) begin s = lo; msat[k] = 1; end
         macc[k] = s;
         mcnt[k]++;
         if (mcnt[k] == n_acc(k)) begin
            fv[k][wp[k] % 8] = s;
            fs[k][wp[k] % 8] = msat[k];
            wp[k]++;
            hold[k] = 1;
         end
      end
   endtask

   task automatic cycle(input bit v0, input longint x0, input bit r0, input bit c0,
                        input bit v1, input longint x1, input bit r1, input bit c1);
      iv0 = v0; val0 = 18'(x0); rdy0 = r0; clr0 = c0;
      iv1 = v1; val1 = 18'(x1); rdy1 = r1; clr1 = c1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("in_ready[%0d]", k), longint'(in_rdy[k]),
             longint'(!hold[k] && !((k == 2) ? c1 : c0)));
         chk($sformatf("out_valid[%0d]", k), longint'(out_vld[k]), longint'(hold[k]));
         chk($sformatf("count[%0d]", k), longint'(cnt[k]), longint'(mcnt[k]));
      end
      @(posedge clk); #1;
      step(0, iv0, longint'(val0), rdy0, clr0);
      step(1, iv0, longint'(val0), rdy0, clr0);
      step(2, iv1, longint'(val1), rdy1, clr1);
   endtask

   task automatic feed0(input longint x, input bit r);
      cycle(1, x, r, 0, 0, 0, 1, 0);
   endtask

   // Monitor: every output transfer is checked against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            if (out_vld[k] && ((k == 2) ? rdy1 : rdy0) && !((k == 2) ? clr1 : clr0)) begin
               if (rp[k] == wp[k]) begin
                  chk($sformatf("unexpected_out[%0d]", k), 1, 0);
               end else begin
                  chk($sformatf("out_value[%0d]", k), outv[k], fv[k][rp[k] % 8]);
                  chk($sformatf("out_sat[%0d]", k), longint'(out_st[k]), longint'(fs[k][rp[k] % 8]));
                  rp[k]++;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   longint hv0;
   initial begin
      for (int k = 0; k < 3; k++) begin wp[k] = 0; rp[k] = 0; end
      model_reset();
      #12;
      for (int k = 0; k < 3; k++) begin
         chk("reset_out_valid", longint'(out_vld[k]), 0);
         chk("reset_out_value", outv[k], 0);
         chk("reset_out_sat", longint'(out_st[k]), 0);
         chk("reset_count", longint'(cnt[k]), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Four products of 5743: A sums to 22972, B sees floor(5743/4)=1435 each.
      for (int i = 0; i < 4; i++) feed0(5743, 1);
      chk("t1_value", outv[0], 22972);
      chk("t1_sat", longint'(out_st[0]), 0);
      feed0(0, 1);

      // Saturating frames in B, both polarities.
      for (int i = 0; i < 4; i++) feed0(131071, 1);
      chk("t2_pos_sat", outv[1], 8191);
      feed0(0, 1);
      for (int i = 0; i < 4; i++) feed0(-131072, 1);
      chk("t2_neg_sat", outv[1], -8192);
      feed0(0, 1);

      // Floor truncation in B: 7,-7,3,-1 -> 1,-2,0,-1.
      feed0(7, 1); feed0(-7, 1); feed0(3, 1); feed0(-1, 0);
      chk("t3_floor", outv[1], -2);

      // Stall in HOLD for 5 cycles with input pending, then drain.
      hv0 = outv[0];
      for (int i = 0; i < 5; i++) begin
         cycle(1, 100, 0, 0, 0, 0, 1, 0);
         chk("t4_stable", outv[0], hv0);
      end
      feed0(100, 1);
      chk("t4_count", longint'(cnt[0]), 0);

      // clear at count 2 with a valid input, then a clean frame.
      feed0(1000, 1); feed0(2000, 1);
      cycle(1, 3000, 1, 1, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) feed0(10 + i, 1);
      chk("t5_clean_sum", outv[0], 46);
      feed0(0, 1);

      // clear while holding with out_ready high discards the result.
      for (int i = 0; i < 4; i++) feed0(50, 0);
      cycle(0, 0, 1, 1, 0, 0, 1, 0);
      chk("t5_discard", longint'(out_vld[0]), 0);

      // Asynchronous reset between edges at count 3.
      for (int i = 0; i < 3; i++) feed0(777, 1);
      iv0 = 0; iv1 = 0; clr0 = 0; clr1 = 0;
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("arst_out_valid", longint'(out_vld[k]), 0);
         chk("arst_out_value", outv[k], 0);
         chk("arst_out_sat", longint'(out_st[k]), 0);
         chk("arst_count", longint'(cnt[k]), 0);
      end
      model_reset();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Randomized traffic on both groups.
      for (int i = 0; i < 3000; i++) begin
         longint x0, x1;
         x0 = ($urandom % 2 == 0) ? longint'($signed(18'($urandom)))
                                  : longint'($urandom_range(0, 4000)) - 2000;
         x1 = longint'($signed(18'($urandom)));
         cycle(($urandom % 4) != 0, x0, ($urandom % 3) != 0, ($urandom % 40) == 0,
               ($urandom % 3) != 0, x1, ($urandom % 2) != 0, ($urandom % 30) == 0);
      end
      cycle(0, 0, 1, 0, 0, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
